// File: rtl/chunked_adder.sv
// chunked_adder: multi-cycle adder/subtractor that adds CHUNK bits per clock,
// LSB first, holding the inter-chunk carry in a register (start/busy/done handshake).
module chunked_adder #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             cout,
    output logic             ovf
);
    localparam int NCH = WIDTH / CHUNK;
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_c;
    logic [CW-1:0]    r_cnt;
    logic [CHUNK-1:0] w_sum;
    logic [CHUNK:0]   w_cy;
    logic [WIDTH-1:0] w_res;
    logic             w_load;
    logic             w_last;

    // Operands shift right one chunk per cycle, so the active chunk is always at the LSBs.
    always_comb begin
        w_cy    = '0;
        w_sum   = '0;
        w_cy[0] = r_c;
        for (int i = 0; i < CHUNK; i++) begin
            w_sum[i]  = r_a[i] ^ r_b[i] ^ w_cy[i];
            w_cy[i+1] = (r_a[i] & r_b[i]) | (w_cy[i] & (r_a[i] ^ r_b[i]));
        end
        w_res = WIDTH'({w_sum, r_res} >> CHUNK);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_last = 1'b0;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_load = 1'b1;
                    w_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (r_cnt == CW'(NCH - 1)) begin
                    w_last = 1'b1;
                    w_next = DONE;
                end
            end
            DONE: begin
                done   = 1'b1;
                w_next = IDLE;
                if (start) begin
                    w_load = 1'b1;
                    w_next = RUN;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Subtraction is A + ~B + 1, so the carry register doubles as the "+1".
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_a   <= '0;
            r_b   <= '0;
            r_c   <= 1'b0;
            r_cnt <= '0;
            r_res <= '0;
            S     <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else if (w_load) begin
            r_a   <= A;
            r_b   <= sub ? ~B : B;
            r_c   <= sub | cin;
            r_cnt <= '0;
        end else if (busy) begin
            r_a   <= r_a >> CHUNK;
            r_b   <= r_b >> CHUNK;
            r_c   <= w_cy[CHUNK];
            r_res <= w_res;
            r_cnt <= r_cnt + CW'(1);
            if (w_last) begin
                S    <= w_res;
                cout <= w_cy[CHUNK];
                ovf  <= w_cy[CHUNK] ^ w_cy[CHUNK-1];
            end
        end
    end
endmodule

// File: tb/tb_chunked_adder.sv
// Scoreboard bench for chunked_adder: one 4-bit instance and 8-bit instances
// with CHUNK = 1, 2, 4, 8; a negedge monitor checks every done pulse.
module tb_chunked_adder;
    logic       clk = 1'b0;
    logic       rstn;
    logic [7:0] a_in     [5];
    logic [7:0] b_in     [5];
    logic       start_in [5];
    logic       sub_in   [5];
    logic       cin_in   [5];
    logic       busy_o   [5];
    logic       done_o   [5];
    logic       cout_o   [5];
    logic       ovf_o    [5];
    logic [3:0] s4w;
    logic [7:0] s_o      [1:4];

    typedef struct {
        int         d;
        logic [7:0] s;
        logic       c;
        logic       o;
        int         cyc;
    } exp_t;

    exp_t sbq [$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   busycnt [5];
    logic prevdone [5];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    chunked_adder #(.WIDTH(4), .CHUNK(1)) u_w4 (
        .clk(clk), .rstn(rstn), .start(start_in[0]), .sub(sub_in[0]),
        .A(a_in[0][3:0]), .B(b_in[0][3:0]), .cin(cin_in[0]),
        .busy(busy_o[0]), .done(done_o[0]), .S(s4w), .cout(cout_o[0]), .ovf(ovf_o[0])
    );

    for (genvar g = 1; g < 5; g++) begin : g8
        chunked_adder #(.WIDTH(8), .CHUNK(1 << (g - 1))) u_w8 (
            .clk(clk), .rstn(rstn), .start(start_in[g]), .sub(sub_in[g]),
            .A(a_in[g]), .B(b_in[g]), .cin(cin_in[g]),
            .busy(busy_o[g]), .done(done_o[g]), .S(s_o[g]), .cout(cout_o[g]), .ovf(ovf_o[g])
        );
    end

    function automatic int nch_of(int d);
        case (d)
            0: return 4;
            1: return 8;
            2: return 4;
            3: return 2;
            default: return 1;
        endcase
    endfunction

    function automatic logic [7:0] get_s(int d);
        if (d == 0) return {4'b0000, s4w};
        return s_o[d];
    endfunction

    // Reference 8-bit model: {ovf, cout, S}
    function automatic logic [9:0] model8(logic [7:0] a, logic [7:0] b, logic s, logic c);
        logic [7:0] bb;
        logic [8:0] full;
        logic       ov;
        bb   = s ? ~b : b;
        full = {1'b0, a} + {1'b0, bb} + {8'd0, (s | c)};
        ov   = (a[7] == bb[7]) && (full[7] != a[7]);
        return {ov, full[8], full[7:0]};
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 5; d++) begin
            if (!rstn) begin
                busycnt[d] = 0;
            end else begin
                if (busy_o[d]) busycnt[d]++;
                if (done_o[d]) begin
                    chk("done_single_cycle", {31'd0, prevdone[d]}, 32'd0);
                    if (sbq.size() == 0) begin
                        chk("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        exp_t e;
                        e = sbq.pop_front();
                        chk("done_instance", d, e.d);
                        chk("S", {24'd0, get_s(d)}, {24'd0, e.s});
                        chk("cout", {31'd0, cout_o[d]}, {31'd0, e.c});
                        chk("ovf", {31'd0, ovf_o[d]}, {31'd0, e.o});
                        chk("done_cycle", cyc, e.cyc);
                        chk("busy_cycles", busycnt[d], nch_of(d));
                    end
                    busycnt[d] = 0;
                end
            end
            prevdone[d] = done_o[d];
        end
    end

    task automatic issue(int d, logic [7:0] a, logic [7:0] b, logic s, logic c,
                         logic [7:0] es, logic ec, logic eo, bit keep);
        exp_t e;
        @(negedge clk);
        a_in[d]     = a;
        b_in[d]     = b;
        sub_in[d]   = s;
        cin_in[d]   = c;
        start_in[d] = 1'b1;
        e.d = d; e.s = es; e.c = ec; e.o = eo; e.cyc = cyc + 1 + nch_of(d);
        sbq.push_back(e);
        @(negedge clk);
        if (!keep) start_in[d] = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sbq.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("drain_timeout", sbq.size(), 0);
        sbq.delete();
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic [7:0] ra, rb;
        logic       rs, rc;
        logic [9:0] m;
        exp_t       e;
        rstn = 1'b0;
        for (int d = 0; d < 5; d++) begin
            a_in[d] = '0; b_in[d] = '0; start_in[d] = 1'b0;
            sub_in[d] = 1'b0; cin_in[d] = 1'b0; busycnt[d] = 0; prevdone[d] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 5; d++) begin
            chk("rst_busy", {31'd0, busy_o[d]}, 0);
            chk("rst_done", {31'd0, done_o[d]}, 0);
            chk("rst_S", {24'd0, get_s(d)}, 0);
            chk("rst_cout", {31'd0, cout_o[d]}, 0);
            chk("rst_ovf", {31'd0, ovf_o[d]}, 0);
        end
        #2 rstn = 1'b1;

        // 4-bit, CHUNK=1
        issue(0, 8'h2, 8'hC, 0, 0, 8'hE, 0, 0, 0); drain();
        issue(0, 8'h6, 8'h9, 0, 0, 8'hF, 0, 0, 0); drain();
        issue(0, 8'h3, 8'h9, 0, 0, 8'hC, 0, 0, 0); drain();
        issue(0, 8'h5, 8'h5, 0, 0, 8'hA, 0, 1, 0); drain();
        issue(0, 8'h3, 8'h5, 1, 0, 8'hE, 0, 0, 0); drain();
        issue(0, 8'h8, 8'h1, 1, 0, 8'h7, 1, 1, 0); drain();

        // 8-bit, CHUNK=4 with carry in
        issue(3, 8'hFF, 8'h01, 0, 1, 8'h01, 1, 0, 0); drain();

        // Boundaries
        issue(2, 8'hFF, 8'h01, 0, 0, 8'h00, 1, 0, 0); drain();
        issue(2, 8'h5A, 8'h5A, 1, 1, 8'h00, 1, 0, 0); drain();
        issue(4, 8'h80, 8'h01, 1, 0, 8'h7F, 1, 1, 0); drain();

        // start pulsed mid-RUN is ignored
        issue(1, 8'h3C, 8'h42, 0, 0, 8'h7E, 0, 0, 0);
        a_in[1] = 8'hFF; b_in[1] = 8'hFF; cin_in[1] = 1'b1; start_in[1] = 1'b1;
        @(negedge clk);
        start_in[1] = 1'b0;
        drain();

        // start held through DONE: back-to-back
        issue(1, 8'h70, 8'h20, 0, 0, 8'h90, 0, 1, 1);
        repeat (8) @(negedge clk);
        chk("b2b_done_seen", {31'd0, done_o[1]}, 1);
        a_in[1] = 8'h10; b_in[1] = 8'h20; sub_in[1] = 1'b1;
        e.d = 1; e.s = 8'hF0; e.c = 1'b0; e.o = 1'b0; e.cyc = cyc + 1 + 8;
        sbq.push_back(e);
        @(negedge clk);
        start_in[1] = 1'b0;
        drain();

        // Asynchronous reset during RUN cycle 3
        issue(1, 8'h12, 8'h34, 0, 0, 8'h46, 0, 0, 0);
        repeat (2) @(negedge clk);
        chk("pre_rst_busy", {31'd0, busy_o[1]}, 1);
        void'(sbq.pop_back());
        #2 rstn = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy_o[1]}, 0);
        chk("abort_S", {24'd0, get_s(1)}, 0);
        chk("abort_cout", {31'd0, cout_o[1]}, 0);
        chk("abort_ovf", {31'd0, ovf_o[1]}, 0);
        @(negedge clk);
        #2 rstn = 1'b1;
        repeat (12) @(negedge clk);
        issue(1, 8'h0F, 8'h01, 0, 1, 8'h11, 0, 0, 0); drain();

        // Random regression over all 8-bit chunk sizes
        for (int d = 1; d < 5; d++) begin
            for (int i = 0; i < 8; i++) begin
                ra = 8'($urandom); rb = 8'($urandom);
                rs = 1'($urandom); rc = 1'($urandom);
                m  = model8(ra, rb, rs, rc);
                issue(d, ra, rb, rs, rc, m[7:0], m[8], m[9], 0);
                drain();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
